// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Instruction fetch stage. Holds a 24-bit byte-address fetch PC that drives
//   the instruction ROM directly, registers the returned 32-bit word together
//   with its address, and offers it to decode over a valid/ready handshake.
//   Redirects (branches/jumps) flush the registered instruction and restart
//   fetching at a new address. A misaligned redirect target is fatal: the
//   unit parks in a trap state until reset.
//
// Parameters:
//   RESET_VECTOR      first byte address fetched after reset (bits [1:0]
//                     are ignored and treated as zero)
//
// Ports:
//   clk_in            single clock, rising edge
//   rst_n_in          asynchronous active-low reset
//   rom_addr_out[23:0]  byte address presented to the instruction ROM
//   rom_data_in[31:0]   combinational ROM word for rom_addr_out
//   instr_out[31:0]     registered instruction offered to decode
//   pc_out[23:0]        byte address of instr_out
//   valid_out           instr_out/pc_out hold a live instruction
//   ready_in            decode accepts this cycle
//   redirect_in         branch/jump taken
//   redirect_addr_in[23:0]  new fetch byte address
//   misalign_out        high while parked in the trap state
//   fetch_cnt_out[31:0] completed handshakes (only with FETCH_PERF_CNT_EN)
//
// Configuration:
//   FETCH_PERF_CNT_EN   when defined, adds fetch_cnt_out and its counter.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [23:0] RESET_VECTOR = 24'h000000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic [23:0] rom_addr_out,
    input  logic [31:0] rom_data_in,
    output logic [31:0] instr_out,
    output logic [23:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic        redirect_in,
    input  logic [23:0] redirect_addr_in,
    output logic        misalign_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_out
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    // Low two bits of the reset vector are forced to zero so the first
    // fetch is always word aligned.
    localparam logic [23:0] BOOT_PC = {RESET_VECTOR[23:2], 2'b00};

    state_t      state;
    logic [23:0] fetch_pc;

    assign rom_addr_out = fetch_pc;

    // Main FSM. All outputs are registered here. Priority in RUN is
    // redirect > load > stall; a redirect never loads in the same cycle,
    // so the first instruction from the new target becomes valid one edge
    // after the redirect edge. Wrap of fetch_pc at 2^24 falls out of the
    // 24-bit adder and is intentionally silent.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= BOOT;
            fetch_pc     <= BOOT_PC;
            instr_out    <= 32'h0;
            pc_out       <= 24'h0;
            valid_out    <= 1'b0;
            misalign_out <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    // One idle cycle after reset; redirects are ignored here.
                    state <= RUN;
                end

                RUN: begin
                    if (redirect_in) begin
                        valid_out <= 1'b0;
                        fetch_pc  <= redirect_addr_in;
                        if (redirect_addr_in[1:0] != 2'b00) begin
                            misalign_out <= 1'b1;
                            state        <= TRAP;
                        end
                    end else if (!valid_out || ready_in) begin
                        instr_out <= rom_data_in;
                        pc_out    <= fetch_pc;
                        valid_out <= 1'b1;
                        fetch_pc  <= fetch_pc + 24'd4;
                    end
                end

                TRAP: begin
                    // Terminal until reset: nothing loads, redirects ignored.
                    valid_out    <= 1'b0;
                    misalign_out <= 1'b1;
                end

                default: begin
                    state     <= TRAP;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic handshake;

    // A handshake completes on any RUN edge with valid and ready high,
    // including the edge that also carries a redirect.
    assign handshake = (state == RUN) && valid_out && ready_in;

    // Free-running handshake counter, wraps naturally at 2^32.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fetch_cnt_out <= 32'h0;
        end else if (handshake) begin
            fetch_cnt_out <= fetch_cnt_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Purpose:
//   Directed testbench for instr_fetch_unit. Two instances are used: one
//   with RESET_VECTOR=0x000100 for sequencing, stall, redirect, trap and
//   reset behaviour, and one with RESET_VECTOR=0xFFFFF8 for PC wrap-around.
//   The ROM is modelled combinationally by romWord(); expected values are
//   hand-computed addresses fed through that same ROM function.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk_in;

    logic        rst_n_a;
    logic [23:0] rom_addr_a;
    logic [31:0] rom_data_a;
    logic [31:0] instr_a;
    logic [23:0] pc_a;
    logic        valid_a;
    logic        ready_a;
    logic        redirect_a;
    logic [23:0] redirect_addr_a;
    logic        misalign_a;

    logic        rst_n_b;
    logic [23:0] rom_addr_b;
    logic [31:0] rom_data_b;
    logic [31:0] instr_b;
    logic [23:0] pc_b;
    logic        valid_b;
    logic        ready_b;
    logic        redirect_b;
    logic [23:0] redirect_addr_b;
    logic        misalign_b;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_a;
    logic [31:0] cnt_b;
`endif

    int errors;
    int checks;

    // ROM contents: a recognisable word derived from the address.
    function automatic logic [31:0] romWord(input logic [23:0] a);
        return {8'hC3, a ^ 24'h5A5A5A};
    endfunction

    assign rom_data_a = romWord(rom_addr_a);
    assign rom_data_b = romWord(rom_addr_b);

    instr_fetch_unit #(.RESET_VECTOR(24'h000100)) dut_a (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_a),
        .rom_addr_out     (rom_addr_a),
        .rom_data_in      (rom_data_a),
        .instr_out        (instr_a),
        .pc_out           (pc_a),
        .valid_out        (valid_a),
        .ready_in         (ready_a),
        .redirect_in      (redirect_a),
        .redirect_addr_in (redirect_addr_a),
        .misalign_out     (misalign_a)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_out    (cnt_a)
`endif
    );

    instr_fetch_unit #(.RESET_VECTOR(24'hFFFFF8)) dut_b (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_b),
        .rom_addr_out     (rom_addr_b),
        .rom_data_in      (rom_data_b),
        .instr_out        (instr_b),
        .pc_out           (pc_b),
        .valid_out        (valid_b),
        .ready_in         (ready_b),
        .redirect_in      (redirect_b),
        .redirect_addr_in (redirect_addr_b),
        .misalign_out     (misalign_b)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_out    (cnt_b)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic applyStimulus();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkLive(input string tag, input logic [23:0] exp_pc);
        checkOutput({tag, "_valid"}, {31'h0, valid_a}, 32'h1);
        checkOutput({tag, "_pc"}, {8'h0, pc_a}, {8'h0, exp_pc});
        checkOutput({tag, "_instr"}, instr_a, romWord(exp_pc));
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        rst_n_a         = 1'b0;
        rst_n_b         = 1'b0;
        ready_a         = 1'b1;
        redirect_a      = 1'b0;
        redirect_addr_a = 24'h0;
        ready_b         = 1'b1;
        redirect_b      = 1'b0;
        redirect_addr_b = 24'h0;

        // ---------------- Reset state ----------------
        applyStimulus();
        applyStimulus();
        checkOutput("rst_valid", {31'h0, valid_a}, 32'h0);
        checkOutput("rst_instr", instr_a, 32'h0);
        checkOutput("rst_pc", {8'h0, pc_a}, 32'h0);
        checkOutput("rst_misalign", {31'h0, misalign_a}, 32'h0);
        checkOutput("rst_romaddr", {8'h0, rom_addr_a}, 32'h100);

        // ---------------- Straight-line fetch ----------------
        $display("[TB] sequential fetch from 0x100");
        rst_n_a = 1'b1;
        applyStimulus();
        checkOutput("boot_valid", {31'h0, valid_a}, 32'h0);
        applyStimulus();
        checkLive("seq0", 24'h000100);
        applyStimulus();
        checkLive("seq1", 24'h000104);
        applyStimulus();
        checkLive("seq2", 24'h000108);

        // Stall one cycle, then reset asynchronously mid-stall.
        ready_a = 1'b0;
        applyStimulus();
        checkLive("prestall", 24'h000108);
        #2;
        rst_n_a = 1'b0;
        #1;
        checkOutput("async_valid", {31'h0, valid_a}, 32'h0);
        checkOutput("async_pc", {8'h0, pc_a}, 32'h0);
        checkOutput("async_instr", instr_a, 32'h0);
        checkOutput("async_romaddr", {8'h0, rom_addr_a}, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("async_cnt", cnt_a, 32'h0);
`endif

        // ---------------- Stall / redirect ----------------
        $display("[TB] stall and redirect");
        ready_a = 1'b1;
        applyStimulus();
        rst_n_a = 1'b1;
        applyStimulus();
        applyStimulus();
        checkLive("s_first", 24'h000100);
        applyStimulus();
        checkLive("s_second", 24'h000104);
        ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkLive("stall", 24'h000104);
            checkOutput("stall_romaddr", {8'h0, rom_addr_a}, 32'h108);
        end
        ready_a = 1'b1;
        applyStimulus();
        checkLive("resume", 24'h000108);
        applyStimulus();
        checkLive("pre_redir", 24'h00010C);

        redirect_a      = 1'b1;
        redirect_addr_a = 24'h000040;
        applyStimulus();
        redirect_a = 1'b0;
        checkOutput("flush_valid", {31'h0, valid_a}, 32'h0);
        checkOutput("flush_romaddr", {8'h0, rom_addr_a}, 32'h40);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("cnt_after_redir", cnt_a, 32'd4);
`endif
        applyStimulus();
        checkLive("redir0", 24'h000040);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus();
            checkLive("redir_run", 24'h000040 + 24'(4 * i));
        end
`ifdef FETCH_PERF_CNT_EN
        checkOutput("cnt_ten", cnt_a, 32'd10);
`endif

        // ---------------- Misaligned redirect / trap ----------------
        $display("[TB] misaligned redirect");
        ready_a         = 1'b0;
        redirect_a      = 1'b1;
        redirect_addr_a = 24'h000042;
        applyStimulus();
        redirect_a = 1'b0;
        ready_a    = 1'b1;
        checkOutput("trap_misalign", {31'h0, misalign_a}, 32'h1);
        checkOutput("trap_valid", {31'h0, valid_a}, 32'h0);
        checkOutput("trap_romaddr", {8'h0, rom_addr_a}, 32'h42);
        applyStimulus();
        applyStimulus();
        checkOutput("trap_hold_mis", {31'h0, misalign_a}, 32'h1);
        checkOutput("trap_hold_valid", {31'h0, valid_a}, 32'h0);
        redirect_a      = 1'b1;
        redirect_addr_a = 24'h000080;
        applyStimulus();
        redirect_a = 1'b0;
        checkOutput("trap_ign_romaddr", {8'h0, rom_addr_a}, 32'h42);
        checkOutput("trap_ign_valid", {31'h0, valid_a}, 32'h0);
        checkOutput("trap_ign_mis", {31'h0, misalign_a}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("trap_cnt", cnt_a, 32'd10);
`endif
        #2;
        rst_n_a = 1'b0;
        #1;
        checkOutput("trap_rst_mis", {31'h0, misalign_a}, 32'h0);
        checkOutput("trap_rst_valid", {31'h0, valid_a}, 32'h0);
        checkOutput("trap_rst_romaddr", {8'h0, rom_addr_a}, 32'h100);

        // ---------------- Wrap-around instance ----------------
        $display("[TB] PC wrap-around from 0xFFFFF8");
        applyStimulus();
        rst_n_b = 1'b1;
        applyStimulus();
        checkOutput("wrap_boot_valid", {31'h0, valid_b}, 32'h0);
        applyStimulus();
        checkOutput("wrap_pc0", {8'h0, pc_b}, 32'hFFFFF8);
        checkOutput("wrap_instr0", instr_b, romWord(24'hFFFFF8));
        applyStimulus();
        checkOutput("wrap_pc1", {8'h0, pc_b}, 32'hFFFFFC);
        applyStimulus();
        checkOutput("wrap_pc2", {8'h0, pc_b}, 32'h000000);
        checkOutput("wrap_instr2", instr_b, romWord(24'h000000));
        checkOutput("wrap_mis", {31'h0, misalign_b}, 32'h0);
        applyStimulus();
        checkOutput("wrap_pc3", {8'h0, pc_b}, 32'h000004);
        checkOutput("wrap_valid", {31'h0, valid_b}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
